// File: rtl/bitstream_decoder_if.sv
// Handshake/data bundle between a bitstream_decoder and its neuron source / readout consumer.
interface bitstream_decoder_if #(
    parameter int unsigned OUT_W = 9
);
    logic             start;
    logic             bit_in;
    logic             busy;
    logic [OUT_W-1:0] value_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output start,
        output bit_in,
        output out_ready,
        input  busy,
        input  value_out,
        input  out_valid
    );

    modport slave (
        input  start,
        input  bit_in,
        input  out_ready,
        output busy,
        output value_out,
        output out_valid
    );
endinterface

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over WINDOW_LEN cycles and presents the count via valid/ready.
// Optional macro BIPOLAR_EN: value_out becomes signed 2*ones - WINDOW_LEN (one extra bit wide).
module bitstream_decoder #(
    parameter int unsigned WINDOW_LEN = 256
) (
    input  logic                clk,
    input  logic                rst,
    bitstream_decoder_if.slave  bus
);

    localparam int unsigned COUNT_W = $clog2(WINDOW_LEN + 1);
    localparam int unsigned SAMP_W  = $clog2(WINDOW_LEN);
`ifdef BIPOLAR_EN
    localparam int unsigned OUT_W   = COUNT_W + 1;
`else
    localparam int unsigned OUT_W   = COUNT_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COUNT_W-1:0]  r_ones_cnt;
    logic [COUNT_W-1:0]  w_ones_nxt;
    logic [SAMP_W-1:0]   r_sample_cnt;
    logic [SAMP_W-1:0]   w_sample_nxt;
    logic [OUT_W-1:0]    r_value_out;
    logic [OUT_W-1:0]    w_value_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    logic [COUNT_W-1:0]  w_final_sum;
    logic [OUT_W-1:0]    w_result;
    logic                w_last;

    // Sum including the current sample; only consumed in ACCUM so an X on bit_in elsewhere is harmless
    assign w_final_sum = r_ones_cnt + COUNT_W'(bus.bit_in);
    assign w_last      = (r_sample_cnt == SAMP_W'(WINDOW_LEN - 1));

`ifdef BIPOLAR_EN
    assign w_result = {w_final_sum, 1'b0} - OUT_W'(WINDOW_LEN);
`else
    assign w_result = w_final_sum;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ones_cnt   <= '0;
            r_sample_cnt <= '0;
            r_value_out  <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ones_cnt   <= w_ones_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_value_out  <= w_value_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_ones_nxt      = r_ones_cnt;
        w_sample_nxt    = r_sample_cnt;
        w_value_nxt     = r_value_out;
        w_out_valid_nxt = r_out_valid;
        w_busy_nxt      = r_busy;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = ST_ACCUM;
                    w_ones_nxt   = '0;
                    w_sample_nxt = '0;
                    w_busy_nxt   = 1'b1;
                end
            end
            ST_ACCUM: begin
                w_ones_nxt = w_final_sum;
                if (w_last) begin
                    w_sample_nxt    = '0;
                    w_value_nxt     = w_result;
                    w_out_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = ST_HOLD;
                end else begin
                    w_sample_nxt = r_sample_cnt + SAMP_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_out_valid && bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (bus.start) begin
                        w_state_nxt  = ST_ACCUM;
                        w_ones_nxt   = '0;
                        w_sample_nxt = '0;
                        w_busy_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    assign bus.busy      = r_busy;
    assign bus.value_out = r_value_out;
    assign bus.out_valid = r_out_valid;

endmodule
